// File: rtl/debounced_input_pio.sv
// Debounced parallel input port with an Avalon-MM register interface.
// Edge capture with write-1-to-clear and a masked, registered level irq.
module debounced_input_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          INVERT          = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  typedef logic [CW-1:0] cnt_t;

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise, fall, cap_set;
  logic [WIDTH-1:0] wdata, cap_clr;
  logic [1:0]       mode_q, mode_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_en, rd_en;
  logic             unused_wd;

  assign raw       = INVERT ? ~in_port : in_port;
  assign wdata     = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign wr_en     = chipselect & write;
  assign rd_en     = chipselect & read;

  // Stable bit flips once the difference has held for the full window.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    cnt_t cnt_q, cnt_d;
    logic stb_d;

    always_comb begin
      cnt_d = '0;
      stb_d = stable_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q == CNT_LAST) begin
          stb_d = ~stable_q[i];
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stable_d[i] = stb_d;
  end

  assign rise = stable_q & ~stable_dly_q;
  assign fall = ~stable_q & stable_dly_q;

  always_comb begin
    cap_set = '0;
    unique case (mode_q)
      2'b00:   cap_set = rise;
      2'b01:   cap_set = fall;
      2'b10:   cap_set = rise | fall;
      default: cap_set = '0;
    endcase
  end

  always_comb begin
    mask_d  = mask_q;
    mode_d  = mode_q;
    cap_clr = '0;
    if (wr_en) begin
      unique case (address)
        2'd1:    mask_d  = wdata;
        2'd2:    cap_clr = wdata;
        2'd3:    mode_d  = writedata[1:0];
        default: ;
      endcase
    end
    // A new edge outranks a simultaneous clear.
    cap_d = (cap_q & ~cap_clr) | cap_set;
    irq_d = |(cap_q & mask_q);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (address)
        2'd0: rdata_d = 32'(stable_q);
        2'd1: rdata_d = 32'(mask_q);
        2'd2: rdata_d = 32'(cap_q);
        2'd3: rdata_d = {30'd0, mode_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      mask_q       <= '0;
      cap_q        <= '0;
      mode_q       <= 2'b00;
      irq_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      mask_q       <= mask_d;
      cap_q        <= cap_d;
      mode_q       <= mode_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_debounced_input_pio.sv
// Bench for debounced_input_pio: directed steps plus random traffic,
// checked against a sliding-window reference model.
module tb_debounced_input_pio;

  localparam int W  = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  in_port = 4'hF;
  logic [1:0]    addr = 2'd0;
  logic          cs = 1'b0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [31:0]   wd = 32'd0;
  logic [31:0]   readdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  debounced_input_pio #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC),
    .INVERT(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .address(addr),
    .chipselect(cs),
    .read(rd),
    .write(wr),
    .writedata(wd),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference: a channel's level flips when the last DC synchronised
  // samples all disagree with it.
  logic [W-1:0]  m_s1, m_s2, m_stab, m_prev;
  logic [W-1:0]  m_cap, m_mask;
  logic [1:0]    m_mode;
  logic          m_irq;
  logic [31:0]   m_rd;
  logic [DC-1:0] win [W];

  function automatic logic [W-1:0] win_toggle();
    logic [W-1:0]  t;
    logic [DC-1:0] nw;
    t = '0;
    for (int i = 0; i < W; i++) begin
      nw   = {win[i][DC-2:0], m_s2[i]};
      t[i] = (nw == {DC{~m_stab[i]}});
    end
    return t;
  endfunction

  function automatic logic [W-1:0] cap_set();
    logic [W-1:0] up, dn;
    up = m_stab & ~m_prev;
    dn = ~m_stab & m_prev;
    case (m_mode)
      2'd0:    return up;
      2'd1:    return dn;
      2'd2:    return up | dn;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1   <= '0;
      m_s2   <= '0;
      m_stab <= '0;
      m_prev <= '0;
      m_cap  <= '0;
      m_mask <= '0;
      m_mode <= 2'd0;
      m_irq  <= 1'b0;
      m_rd   <= '0;
      for (int i = 0; i < W; i++) win[i] <= '0;
    end else begin
      m_s1   <= ~in_port;
      m_s2   <= m_s1;
      for (int i = 0; i < W; i++)
        win[i] <= {win[i][DC-2:0], m_s2[i]};
      m_stab <= m_stab ^ win_toggle();
      m_prev <= m_stab;
      m_cap  <= (m_cap & ~((cs && wr && addr == 2'd2) ?
                wd[W-1:0] : 4'h0)) | cap_set();
      m_irq  <= |(m_cap & m_mask);
      if (cs && wr && addr == 2'd1) m_mask <= wd[W-1:0];
      if (cs && wr && addr == 2'd3) m_mode <= wd[1:0];
      if (cs && rd) begin
        case (addr)
          2'd0: m_rd <= {28'd0, m_stab};
          2'd1: m_rd <= {28'd0, m_mask};
          2'd2: m_rd <= {28'd0, m_cap};
          2'd3: m_rd <= {30'd0, m_mode};
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("readdata", readdata, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wd = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
  endtask

  // Holds a DATA read and returns the tick at which bit 0 first reads 1.
  task automatic watch_data0(output int first);
    first = -1;
    cs = 1'b1; rd = 1'b1; addr = 2'd0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (readdata[0] && first < 0) first = n;
    end
    cs = 1'b0; rd = 1'b0;
  endtask

  int first;
  int hold;
  int op;

  initial begin
    // Reset state
    idle(2);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a));
      chk("rst_reg", readdata, 32'd0);
    end

    // Press key0: stable at 6th edge, readable on the 7th
    in_port = 4'hE;
    watch_data0(first);
    chk("lat_press", 32'(first), 32'd7);
    bus_read(2'd2);
    chk("cap_press", readdata, 32'd1);

    // Short glitch on key1 is rejected, a full-window one is not
    in_port = 4'hC;
    idle(3);
    in_port = 4'hE;
    idle(8);
    bus_read(2'd0);
    chk("glitch_data", readdata, 32'd1);
    bus_read(2'd2);
    chk("glitch_cap", readdata, 32'd1);
    in_port = 4'hC;
    idle(4);
    in_port = 4'hE;
    idle(8);
    bus_read(2'd2);

    // Writes to DATA and writes without chipselect do nothing
    bus_write(2'd0, 32'hF);
    wr = 1'b1; addr = 2'd1; wd = 32'hF;
    idle(2);
    wr = 1'b0;
    bus_read(2'd1);
    chk("nocs_mask", readdata, 32'd0);

    // Masked irq and its clear latency
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFF1);
    bus_write(2'd3, 32'd0);
    in_port = 4'hF;
    idle(10);
    chk("irq_release", {31'd0, irq}, 32'd0);
    in_port = 4'hE;
    idle(10);
    chk("irq_set", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'd1);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    tick();
    chk("irq_clr", {31'd0, irq}, 32'd0);
    bus_read(2'd1);
    chk("mask_rd", readdata, 32'd1);

    // Falling-only capture, then capture disabled
    bus_write(2'd3, 32'hFFFF_FFFD);
    bus_read(2'd3);
    chk("mode_rd", readdata, 32'd1);
    bus_write(2'd2, 32'hF);
    in_port = 4'hA;
    idle(10);
    bus_read(2'd2);
    chk("fall_press", readdata, 32'd0);
    in_port = 4'hE;
    idle(10);
    bus_read(2'd2);
    chk("fall_rel", readdata, 32'd4);
    bus_write(2'd3, 32'd3);
    bus_write(2'd2, 32'hF);
    in_port = 4'hA;
    idle(10);
    in_port = 4'hE;
    idle(10);
    bus_read(2'd2);
    chk("cap_off", readdata, 32'd0);

    // Clear coinciding with a new edge on channel 3 loses
    bus_write(2'd3, 32'd2);
    in_port = 4'h6;
    idle(10);
    bus_read(2'd2);
    chk("both_press", readdata, 32'd8);
    in_port = 4'hE;
    idle(6);
    bus_write(2'd2, 32'd8);
    bus_read(2'd2);
    chk("set_wins", readdata, 32'd8);
    bus_write(2'd2, 32'd8);
    bus_read(2'd2);
    chk("clr_only", readdata, 32'd0);

    // Random traffic against the model
    for (int it = 0; it < 120; it++) begin
      in_port = 4'($urandom);
      hold = int'($urandom_range(1, 7));
      op = int'($urandom_range(0, 3));
      addr = 2'($urandom);
      wd = $urandom;
      cs = (op == 1 || op == 2);
      rd = (op == 1);
      wr = (op == 2 || op == 3);
      idle(hold);
      cs = 1'b0; rd = 1'b0; wr = 1'b0;
    end

    // Reset mid-count with key0 held
    bus_write(2'd3, 32'd0);
    in_port = 4'hF;
    idle(10);
    in_port = 4'hE;
    idle(3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_rd", readdata, 32'd0);
    idle(2);
    reset_n = 1'b1;
    watch_data0(first);
    chk("lat_rst", 32'(first), 32'd7);
    bus_read(2'd2);
    chk("cap_rst", readdata, 32'd1);
    bus_read(2'd3);
    chk("mode_rst", readdata, 32'd0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
